// File: rtl/param_subtractor_pipe.sv
// param_subtractor_pipe: a - b - bin with the borrow chain cut into PIPE_STAGES slices.
// Define PARAM_SUB_OVF_EN to add the registered signed-overflow output ovf.
module param_subtractor_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             valid_in,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef PARAM_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             valid_out
);
  localparam int P = PIPE_STAGES;
  localparam int S = WIDTH / PIPE_STAGES;

  if (WIDTH < 2 || P < 1 || P > WIDTH || (WIDTH % P) != 0) begin : g_bad_cfg
    $error("param_subtractor_pipe: illegal WIDTH/PIPE_STAGES");
  end

  for (genvar k = 0; k < P; k++) begin : g_st
    // bi holds only the subtrahend slices not yet consumed
    localparam int BW = WIDTH - k * S;

    logic [WIDTH-1:0] wi;
    logic [BW-1:0]    bi;
    logic             bri;
    logic             vi;
    logic [S:0]       sl;
    logic [WIDTH-1:0] w_d, w_q;
    logic             br_d, br_q;
    logic             v_d, v_q;

    if (k == 0) begin : g_in
      assign wi  = a;
      assign bi  = b;
      assign bri = bin;
      assign vi  = valid_in;
    end else begin : g_in
      assign wi  = g_st[k-1].w_q;
      assign bi  = g_st[k-1].g_sk.bo_q;
      assign bri = g_st[k-1].br_q;
      assign vi  = g_st[k-1].v_q;
    end

    // w carries finished diff bits below slice k, raw minuend above
    always_comb begin
      sl = {1'b0, wi[k*S +: S]}
         - {1'b0, bi[S-1:0]}
         - {{S{1'b0}}, bri};
      w_d = wi;
      w_d[k*S +: S] = sl[S-1:0];
      br_d = sl[S];
      v_d  = vi;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        w_q  <= '0;
        br_q <= 1'b0;
        v_q  <= 1'b0;
      end else begin
        v_q <= v_d;
        if (vi) begin
          w_q  <= w_d;
          br_q <= br_d;
        end
      end
    end

    if (k < P - 1) begin : g_sk
      logic [BW-S-1:0] bo_d, bo_q;

      always_comb begin
        bo_d = bi[BW-1:S];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          bo_q <= '0;
        end else if (vi) begin
          bo_q <= bo_d;
        end
      end
    end

`ifdef PARAM_SUB_OVF_EN
    if (k == P - 1) begin : g_ovf
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = (wi[WIDTH-1] ^ bi[BW-1]) & (sl[S-1] ^ wi[WIDTH-1]);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ovf_q <= 1'b0;
        end else if (vi) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign diff      = g_st[P-1].w_q;
  assign bout      = g_st[P-1].br_q;
  assign valid_out = g_st[P-1].v_q;
`ifdef PARAM_SUB_OVF_EN
  assign ovf       = g_st[P-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_param_subtractor_pipe.sv
// tb_param_subtractor_pipe: table vectors, hand sequences and random stream
// against an arithmetic model, on PIPE_STAGES = 1, 2 and 8 instances.
module tb_param_subtractor_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a   = '0;
  logic [7:0] b   = '0;
  logic       bin = 1'b0;
  logic       vin = 1'b0;

  logic [2:0] vo_w;
  logic [2:0] bo_w;
  logic [7:0] d_w [3];
`ifdef PARAM_SUB_OVF_EN
  logic [2:0] ov_w;
`endif

  int total = 0;
  int bad   = 0;
  int lat [3] = '{1, 2, 8};

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
  } smp_t;
  smp_t hist [$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  param_subtractor_pipe #(.WIDTH(8), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .valid_in(vin),
    .diff(d_w[0]), .bout(bo_w[0]),
`ifdef PARAM_SUB_OVF_EN
    .ovf(ov_w[0]),
`endif
    .valid_out(vo_w[0])
  );

  param_subtractor_pipe #(.WIDTH(8), .PIPE_STAGES(2)) u_p2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .valid_in(vin),
    .diff(d_w[1]), .bout(bo_w[1]),
`ifdef PARAM_SUB_OVF_EN
    .ovf(ov_w[1]),
`endif
    .valid_out(vo_w[1])
  );

  param_subtractor_pipe #(.WIDTH(8), .PIPE_STAGES(8)) u_p8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .valid_in(vin),
    .diff(d_w[2]), .bout(bo_w[2]),
`ifdef PARAM_SUB_OVF_EN
    .ovf(ov_w[2]),
`endif
    .valid_out(vo_w[2])
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ia,
                       input logic [7:0] ib, input logic ibin);
    vin = v;
    a   = ia;
    b   = ib;
    bin = ibin;
  endtask

  task automatic idle();
    drive(1'b0, 8'($urandom()), 8'($urandom()), 1'($urandom()));
  endtask

  // Expected outputs of a latency-L pipe after hist.size() edges.
  task automatic model(input int L, output logic ev, output logic [7:0] ed,
                       output logic eb, output logic eo);
    int n;
    int r;
    n  = hist.size();
    ev = 1'b0;
    ed = '0;
    eb = 1'b0;
    eo = 1'b0;
    if (n - L >= 0) begin
      ev = hist[n-L].v;
      for (int i = n - L; i >= 0; i--) begin
        if (hist[i].v) begin
          r  = int'(hist[i].a) - int'(hist[i].b) - int'(hist[i].bin);
          ed = 8'(r);
          eb = (r < 0);
          eo = (hist[i].a[7] ^ hist[i].b[7]) & (ed[7] ^ hist[i].a[7]);
          break;
        end
      end
    end
  endtask

  task automatic model_check();
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
    for (int j = 0; j < 3; j++) begin
      model(lat[j], ev, ed, eb, eo);
      chk($sformatf("p%0d valid_out", lat[j]), 32'(vo_w[j]), 32'(ev));
      chk($sformatf("p%0d diff", lat[j]), 32'(d_w[j]), 32'(ed));
      chk($sformatf("p%0d bout", lat[j]), 32'(bo_w[j]), 32'(eb));
`ifdef PARAM_SUB_OVF_EN
      chk($sformatf("p%0d ovf", lat[j]), 32'(ov_w[j]), 32'(eo));
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    hist.push_back('{v: vin, a: a, b: b, bin: bin});
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_zero(input string nm);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s p%0d valid_out", nm, lat[j]), 32'(vo_w[j]), 32'd0);
      chk($sformatf("%s p%0d diff", nm, lat[j]), 32'(d_w[j]), 32'd0);
      chk($sformatf("%s p%0d bout", nm, lat[j]), 32'(bo_w[j]), 32'd0);
`ifdef PARAM_SUB_OVF_EN
      chk($sformatf("%s p%0d ovf", nm, lat[j]), 32'(ov_w[j]), 32'd0);
`endif
    end
  endtask

  task automatic chk_p2(input string nm, input logic ev,
                        input logic [7:0] ed, input logic eb);
    chk({nm, " valid_out"}, 32'(vo_w[1]), 32'(ev));
    chk({nm, " diff"}, 32'(d_w[1]), 32'(ed));
    chk({nm, " bout"}, 32'(bo_w[1]), 32'(eb));
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom());
    endcase
  endfunction

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, d: 8'h00, bo: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h10, b: 8'h01, bin: 1'b0, d: 8'h0F, bo: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 8'hAA, b: 8'hAA, bin: 1'b0, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[6] = '{a: 8'hAA, b: 8'hAA, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[7] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[8] = '{a: 8'h7F, b: 8'h01, bin: 1'b0, d: 8'h7E, bo: 1'b0, ov: 1'b0};

    #3;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    hist.delete();

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
      tick();
      idle();
      tick();
      chk_p2($sformatf("vec%0d", i), 1'b1, vecs[i].d, vecs[i].bo);
`ifdef PARAM_SUB_OVF_EN
      chk($sformatf("vec%0d ovf", i), 32'(ov_w[1]), 32'(vecs[i].ov));
`endif
      tick();
      chk_p2($sformatf("vec%0d hold", i), 1'b0, vecs[i].d, vecs[i].bo);
      for (int w = 0; w < 6; w++) tick();
    end

    drive(1'b1, 8'd9, 8'd4, 1'b0);
    tick();
    drive(1'b1, 8'd4, 8'd9, 1'b0);
    tick();
    chk_p2("gap0", 1'b1, 8'h05, 1'b0);
    idle();
    tick();
    chk_p2("gap1", 1'b1, 8'hFB, 1'b1);
    drive(1'b1, 8'd200, 8'd100, 1'b1);
    tick();
    chk_p2("gap2", 1'b0, 8'hFB, 1'b1);
    idle();
    tick();
    chk_p2("gap3", 1'b1, 8'h63, 1'b0);
    for (int w = 0; w < 8; w++) tick();

    drive(1'b1, 8'h20, 8'h01, 1'b0);
    tick();
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    hist.delete();
    for (int w = 0; w < 10; w++) tick();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) drive(1'b1, rnd8(), rnd8(), 1'($urandom()));
      else idle();
      tick();
    end
    idle();
    for (int w = 0; w < 10; w++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_subtractor_pipe.md
Name: param_subtractor_pipe

Overview:
- Parameterised unsigned subtractor with borrow-in and borrow-out: diff = a - b - bin.
- The borrow chain is split into PIPE_STAGES equal slices, with one register rank per slice, so throughput is one operation per clock.
- It is the inverse-direction companion to the team's param_adder, and the datapath consumer for difference/compare paths.
- A valid flag travels with each operation through the pipeline.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
PIPE_STAGES, 2, number of slices/register ranks; 1..WIDTH; WIDTH % PIPE_STAGES must be 0 (elaboration $error otherwise).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
valid_in  input  1  a/b/bin valid this cycle
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
valid_out  output  1  diff/bout carry a new result this cycle

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers cleared; diff=0, bout=0, valid_out=0 immediately, with no clock needed. Deassertion is taken synchronously at the next edge.
- Slice width S = WIDTH/PIPE_STAGES.
  - Stage k (k=0..PIPE_STAGES-1) computes bits [k*S +: S] using the borrow registered by stage k-1; stage 0 uses bin.
  - Upper-slice operands are delayed k cycles (skew registers).
  - Finished lower-slice results are delayed PIPE_STAGES-1-k cycles (deskew registers).
- Latency: exactly PIPE_STAGES clocks from the edge sampling valid_in=1 to valid_out=1 with the matching result.
  - Example: PIPE_STAGES=1 means the result appears at the next edge.
- Throughput: one operation per clock. There is no backpressure and no ready signal; the consumer must accept every valid_out.
- Valid pipeline: valid_in shifts through PIPE_STAGES flops; valid_out is the last flop.
- Data registers at each rank load only when that rank's incoming valid is 1; otherwise they hold.
  - Consequence: diff/bout keep the last valid result while valid_out=0.
  - Gaps in valid_in never corrupt in-flight operations.
- Arithmetic: per-slice {borrow, d} = {1'b0, a_slice} - {1'b0, b_slice} - borrow_in_slice; borrow = MSB of the (S+1)-bit result.
  - bout = borrow of the top slice.
  - Wrap-around: modulo 2^WIDTH; e.g. 0 - 1 = all-ones with bout=1.
- Boundary cases:
  - a=b, bin=0: diff=0, bout=0.
  - a=b, bin=1: diff=all-ones, bout=1.
  - a=0, b=all-ones, bin=1: diff=0, bout=1.
- Reset mid-operation: all in-flight operations are discarded; no valid_out is produced for them after release.
- X on a/b/bin while valid_in=0 must not propagate to diff/bout.

Optional Feature:
Macro: PARAM_SUB_OVF_EN
- Defined:
  - Extra port ovf (output, 1 bit): signed two's-complement overflow of a - b - bin, i.e. operand signs differ and the result sign differs from a's sign.
  - ovf is registered and aligned with diff (same latency), holds with diff, and resets to 0.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8, PIPE_STAGES=2 unless noted):
1. Basic: a=8'h05, b=8'h03, bin=0, one valid pulse -> 2 clocks later valid_out=1, diff=8'h02, bout=0; next cycle valid_out=0 and diff holds 8'h02.
2. Wrap/borrow: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h00, b=8'hFF, bin=1 -> diff=8'h00, bout=1.
3. Cross-slice borrow: a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0. Also a=8'h10, b=8'h01, bin=0 -> diff=8'h0F, bout=0.
4. Streaming with gap: valid_in pattern 1,1,0,1 with (9,4,0), (4,9,0), (X,X,X), (200,100,1) -> valid_out pattern 1,1,0,1 starting 2 clocks later, with (8'h05,0), (8'hFB,1), held, (8'h63,0).
5. Reset mid-flight: launch a=8'h20, b=8'h01, then pull rst=0 before the result emerges -> valid_out=0, diff=0 immediately; after release no stray valid_out.
6. PARAM_SUB_OVF_EN defined: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, ovf=1. a=8'h7F, b=8'h01 -> diff=8'h7E, ovf=0. Also rerun test 1 with PIPE_STAGES=1 and PIPE_STAGES=8 -> latency 1 and 8 respectively.
